// File: rtl/y86_pkg.sv
// Y86-64 decode-stage shared definitions.
// Instruction codes, register IDs, status codes and the D->E bundle.
package y86_pkg;

  localparam int NREG = 15;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_HLT = 4'h2;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] STAT_INS = 4'h4;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
  } id_ex_t;

  localparam id_ex_t ID_EX_RESET = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    val_c: 64'h0,
    val_a: 64'h0,
    val_b: 64'h0,
    dst_e: RNONE,
    dst_m: RNONE,
    src_a: RNONE,
    src_b: RNONE
  };

  function automatic logic a_from_ra(
    input logic [3:0] ic
  );
    return ic inside {I_CMOV, I_RMMOV,
                      I_OPQ, I_PUSH};
  endfunction

  function automatic logic a_from_rsp(
    input logic [3:0] ic
  );
    return ic inside {I_RET, I_POP};
  endfunction

  function automatic logic b_from_rb(
    input logic [3:0] ic
  );
    return ic inside {I_RMMOV, I_MRMOV,
                      I_OPQ};
  endfunction

  function automatic logic uses_rsp(
    input logic [3:0] ic
  );
    return ic inside {I_CALL, I_RET,
                      I_PUSH, I_POP};
  endfunction

  function automatic logic e_from_rb(
    input logic [3:0] ic
  );
    return ic inside {I_CMOV, I_IRMOV,
                      I_OPQ};
  endfunction

  function automatic logic m_from_ra(
    input logic [3:0] ic
  );
    return ic inside {I_MRMOV, I_POP};
  endfunction

  function automatic logic valp_to_a(
    input logic [3:0] ic
  );
    return ic inside {I_JXX, I_CALL};
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x 64, two combinational reads,
// two writes per cycle with the M port winning a collision.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  output logic [63:0] regs [NREG]
);

  logic [63:0] mem [NREG];

  // RNONE is 15 and never equals an index, so it reads 0
  always_comb begin
    val_a = '0;
    val_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == 4'(i)) val_a = mem[i];
      if (src_b == 4'(i)) val_b = mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREG; i++) begin
        if (dst_e == 4'(i)) mem[i] <= val_e;
        if (dst_m == 4'(i)) mem[i] <= val_m;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++)
      regs[i] = mem[i];
  end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: register IDs, forwarding and
// the D->E pipeline register.
module decode_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [3:0]  D_stat,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  input  logic [3:0]  W_icode,
  output logic [3:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [63:0] reg_mem0,
  output logic [63:0] reg_mem1,
  output logic [63:0] reg_mem2,
  output logic [63:0] reg_mem3,
  output logic [63:0] reg_mem4,
  output logic [63:0] reg_mem5,
  output logic [63:0] reg_mem6,
  output logic [63:0] reg_mem7,
  output logic [63:0] reg_mem8,
  output logic [63:0] reg_mem9,
  output logic [63:0] reg_mem10,
  output logic [63:0] reg_mem11,
  output logic [63:0] reg_mem12,
  output logic [63:0] reg_mem13,
  output logic [63:0] reg_mem14
);

  logic [3:0]  src_a, src_b;
  logic [3:0]  dst_e, dst_m;
  logic [63:0] rf_a, rf_b;
  logic [63:0] val_a, val_b;
  logic        w_en;
  logic [63:0] regs [NREG];
  id_ex_t      e_d, e_q;

  assign w_en = !(W_icode inside {I_HALT, I_NOP});

  y86_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_en),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .dst_m (W_dstM),
    .val_m (W_valM),
    .src_a (src_a),
    .src_b (src_b),
    .val_a (rf_a),
    .val_b (rf_b),
    .regs  (regs)
  );

  always_comb begin
    src_a = RNONE;
    unique case (1'b1)
      a_from_ra(D_icode):  src_a = D_rA;
      a_from_rsp(D_icode): src_a = RRSP;
      default: ;
    endcase
  end

  always_comb begin
    src_b = RNONE;
    unique case (1'b1)
      b_from_rb(D_icode): src_b = D_rB;
      uses_rsp(D_icode):  src_b = RRSP;
      default: ;
    endcase
  end

  always_comb begin
    dst_e = RNONE;
    unique case (1'b1)
      e_from_rb(D_icode): dst_e = D_rB;
      uses_rsp(D_icode):  dst_e = RRSP;
      default: ;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    unique case (1'b1)
      m_from_ra(D_icode): dst_m = D_rA;
      default: ;
    endcase
  end

  // RNONE source is excluded up front, so no stage can match on F
  always_comb begin
    val_a = '0;
    if (valp_to_a(D_icode))
      val_a = D_valP;
    else if (src_a == RNONE)
      val_a = '0;
    else if (src_a == e_dstE)
      val_a = e_valE;
    else if (src_a == M_dstM)
      val_a = m_valM;
    else if (src_a == M_dstE)
      val_a = M_valE;
    else if (src_a == W_dstM)
      val_a = W_valM;
    else if (src_a == W_dstE)
      val_a = W_valE;
    else
      val_a = rf_a;
  end

  always_comb begin
    val_b = '0;
    if (src_b == RNONE)
      val_b = '0;
    else if (src_b == e_dstE)
      val_b = e_valE;
    else if (src_b == M_dstM)
      val_b = m_valM;
    else if (src_b == M_dstE)
      val_b = M_valE;
    else if (src_b == W_dstM)
      val_b = W_valM;
    else if (src_b == W_dstE)
      val_b = W_valE;
    else
      val_b = rf_b;
  end

  always_comb begin
    e_d       = ID_EX_RESET;
    e_d.stat  = D_stat;
    e_d.icode = D_icode;
    e_d.ifun  = D_ifun;
    e_d.val_c = D_valC;
    e_d.val_a = val_a;
    e_d.val_b = val_b;
    e_d.dst_e = dst_e;
    e_d.dst_m = dst_m;
    e_d.src_a = src_a;
    e_d.src_b = src_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= ID_EX_RESET;
    else        e_q <= e_d;
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.val_c;
  assign E_valA  = e_q.val_a;
  assign E_valB  = e_q.val_b;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;

  assign reg_mem0  = regs[0];
  assign reg_mem1  = regs[1];
  assign reg_mem2  = regs[2];
  assign reg_mem3  = regs[3];
  assign reg_mem4  = regs[4];
  assign reg_mem5  = regs[5];
  assign reg_mem6  = regs[6];
  assign reg_mem7  = regs[7];
  assign reg_mem8  = regs[8];
  assign reg_mem9  = regs[9];
  assign reg_mem10 = regs[10];
  assign reg_mem11 = regs[11];
  assign reg_mem12 = regs[12];
  assign reg_mem13 = regs[13];
  assign reg_mem14 = regs[14];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: ID decode, forwarding,
// register-file writes and asynchronous reset.
module tb_decode_stage;

  localparam logic [3:0] F = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  D_icode = 4'h1, D_ifun = 4'h0;
  logic [3:0]  D_rA = F, D_rB = F;
  logic [3:0]  D_stat = 4'h1;
  logic [63:0] D_valC = '0, D_valP = '0;
  logic [3:0]  e_dstE = F;
  logic [63:0] e_valE = '0;
  logic [3:0]  M_dstE = F, M_dstM = F;
  logic [63:0] M_valE = '0, m_valM = '0;
  logic [3:0]  W_dstE = F, W_dstM = F;
  logic [63:0] W_valE = '0, W_valM = '0;
  logic [3:0]  W_icode = 4'h0;

  logic [3:0]  E_stat, E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] rm [15];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB),
    .D_stat(D_stat),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .W_icode(W_icode),
    .E_stat(E_stat), .E_icode(E_icode),
    .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB),
    .reg_mem0(rm[0]),   .reg_mem1(rm[1]),
    .reg_mem2(rm[2]),   .reg_mem3(rm[3]),
    .reg_mem4(rm[4]),   .reg_mem5(rm[5]),
    .reg_mem6(rm[6]),   .reg_mem7(rm[7]),
    .reg_mem8(rm[8]),   .reg_mem9(rm[9]),
    .reg_mem10(rm[10]), .reg_mem11(rm[11]),
    .reg_mem12(rm[12]), .reg_mem13(rm[13]),
    .reg_mem14(rm[14])
  );

  typedef struct {
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] vc, vp;
    logic [3:0]  ed;  logic [63:0] ev;
    logic [3:0]  mde; logic [63:0] mve;
    logic [3:0]  mdm; logic [63:0] mvm;
    logic [3:0]  wde; logic [63:0] wve;
    logic [3:0]  wdm; logic [63:0] wvm;
    logic [63:0] xa, xb;
    logic [3:0]  xde, xdm, xsa, xsb;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle_w();
    W_icode = 4'h0;
    W_dstE = F; W_dstM = F;
    W_valE = '0; W_valM = '0;
  endtask

  initial begin
    // ic fn ra rb vc vp | e | M_E | M_M | W_E | W_M | xa xb xde xdm xsa xsb
    vt[0]  = '{6,0,2,3,0,0, F,0, F,0, F,0, F,0, F,0,
               99,0, 3,F,2,3};
    vt[1]  = '{6,1,2,3,0,0, 2,5, 2,7, F,0, F,0, F,0,
               5,0, 3,F,2,3};
    vt[2]  = '{6,1,2,3,0,0, F,0, 2,7, F,0, F,0, F,0,
               7,0, 3,F,2,3};
    vt[3]  = '{6,2,3,2,0,0, F,0, 3,12, 3,11, F,0, F,0,
               11,99, 2,F,3,2};
    vt[4]  = '{8,0,F,F,'h100,'h40, F,0, F,0, F,0, F,0, F,0,
               'h40,0, 4,F,F,4};
    vt[5]  = '{'hB,0,6,F,0,0, F,0, F,0, F,0, F,0, F,0,
               0,0, 4,6,4,4};
    vt[6]  = '{4,0,2,3,'h10,0, F,0, F,0, F,0, 3,44, 3,33,
               99,33, F,F,2,3};
    vt[7]  = '{3,0,F,7,'h1234,0, F,77, F,0, F,0, F,0, F,0,
               0,0, 7,F,F,F};
    vt[8]  = '{7,3,2,F,'h200,'h88, 2,5, F,0, F,0, F,0, F,0,
               'h88,0, F,F,F,F};
    vt[9]  = '{5,0,5,2,8,0, F,0, F,0, F,0, 2,55, F,0,
               0,55, F,5,F,2};
    vt[10] = '{'hA,0,2,F,0,0, F,0, F,0, F,0, F,0, F,0,
               99,0, 4,F,2,4};
    vt[11] = '{9,0,F,F,0,'h77, F,0, F,0, F,0, F,0, F,0,
               0,0, 4,F,4,4};
    vt[12] = '{2,0,2,6,0,0, F,0, F,0, F,0, F,0, F,0,
               99,0, 6,F,2,F};
    vt[13] = '{8,0,F,F,0,'h50, 4,'h999, F,0, F,0, F,0, F,0,
               'h50,'h999, 4,F,F,4};
    vt[14] = '{6,0,3,3,0,0, F,0, 3,'hBB, F,0, 3,'hAA, F,0,
               'hBB,'hBB, 3,F,3,3};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_E_icode", 64'(E_icode), 64'h1);
    chk("rst_E_stat", 64'(E_stat), 64'h1);
    chk("rst_E_srcA", 64'(E_srcA), 64'hF);
    chk("rst_E_dstM", 64'(E_dstM), 64'hF);
    chk("rst_E_valA", E_valA, 64'h0);
    for (int i = 0; i < 15; i++)
      chk($sformatf("rst_reg%0d", i), rm[i], 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    W_icode = 4'h3; W_dstE = 4'h2; W_valE = 64'd99;
    @(negedge clk);
    chk("irmov_reg2", rm[2], 64'd99);
    idle_w();

    for (int i = 0; i < 15; i++) begin
      D_icode = vt[i].ic; D_ifun = vt[i].fn;
      D_rA = vt[i].ra;    D_rB = vt[i].rb;
      D_valC = vt[i].vc;  D_valP = vt[i].vp;
      e_dstE = vt[i].ed;  e_valE = vt[i].ev;
      M_dstE = vt[i].mde; M_valE = vt[i].mve;
      M_dstM = vt[i].mdm; m_valM = vt[i].mvm;
      W_dstE = vt[i].wde; W_valE = vt[i].wve;
      W_dstM = vt[i].wdm; W_valM = vt[i].wvm;
      @(negedge clk);
      chk($sformatf("v%0d_icode", i), 64'(E_icode), 64'(vt[i].ic));
      chk($sformatf("v%0d_ifun", i), 64'(E_ifun), 64'(vt[i].fn));
      chk($sformatf("v%0d_valC", i), E_valC, vt[i].vc);
      chk($sformatf("v%0d_valA", i), E_valA, vt[i].xa);
      chk($sformatf("v%0d_valB", i), E_valB, vt[i].xb);
      chk($sformatf("v%0d_dstE", i), 64'(E_dstE), 64'(vt[i].xde));
      chk($sformatf("v%0d_dstM", i), 64'(E_dstM), 64'(vt[i].xdm));
      chk($sformatf("v%0d_srcA", i), 64'(E_srcA), 64'(vt[i].xsa));
      chk($sformatf("v%0d_srcB", i), 64'(E_srcB), 64'(vt[i].xsb));
    end

    D_icode = 4'h1; D_rA = F; D_rB = F;
    e_dstE = F; M_dstE = F; M_dstM = F;
    W_icode = 4'h5;
    W_dstE = 4'h5; W_valE = 64'd1;
    W_dstM = 4'h5; W_valM = 64'd2;
    @(negedge clk);
    chk("wr_collide_reg5", rm[5], 64'd2);

    W_icode = 4'h1;
    W_dstE = 4'h6; W_valE = 64'd9; W_dstM = F;
    @(negedge clk);
    chk("wr_nop_reg6", rm[6], 64'd0);

    W_icode = 4'h0;
    @(negedge clk);
    chk("wr_halt_reg6", rm[6], 64'd0);

    W_icode = 4'hB;
    W_dstE = 4'h4; W_valE = 64'h30;
    W_dstM = 4'h7; W_valM = 64'h70;
    @(negedge clk);
    chk("wr_pop_reg4", rm[4], 64'h30);
    chk("wr_pop_reg7", rm[7], 64'h70);
    idle_w();

    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h7;
    D_stat = 4'h4;
    @(negedge clk);
    chk("pre_rst_valA", E_valA, 64'd99);
    chk("pre_rst_valB", E_valB, 64'h70);
    chk("pre_rst_stat", 64'(E_stat), 64'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_icode", 64'(E_icode), 64'h1);
    chk("async_stat", 64'(E_stat), 64'h1);
    chk("async_valA", E_valA, 64'h0);
    chk("async_valB", E_valB, 64'h0);
    chk("async_dstE", 64'(E_dstE), 64'hF);
    chk("async_reg2", rm[2], 64'h0);
    chk("async_reg7", rm[7], 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
